pll_reconfig_ctrl: RTL and testbench

//  Serialises a 16-bit PLL setting into the PLL reconfiguration scan chain, then waits for relock.

---
 rtl/pll_reconfig_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration controller: shifts a 16-bit M/N setting into the PLL scan chain,
// commits it with configupdate, then waits for scandone and a sustained lock.
module pll_reconfig_ctrl #(
    parameter int DATA_WIDTH     = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  trigger,
    input  logic [DATA_WIDTH-1:0] PLL_DATA,
    output logic                  busy,
    output logic                  stable_reconfig,
    output logic                  timeout,
    output logic                  locked,
    output logic                  scanclkena,
    output logic                  scandata,
    output logic                  configupdate,
    input  logic                  scandone,
    input  logic                  pll_locked_in
);

    localparam int BCNT_W = $clog2(DATA_WIDTH) + 1;
    localparam int SCNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam int TCNT_W = 16;
    localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(DATA_WIDTH - 1);
    localparam logic [SCNT_W-1:0] STB_LAST = SCNT_W'(STABLE_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TMO_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT     = 3'd1,
        UPDATE    = 3'd2,
        WAIT_DONE = 3'd3,
        WAIT_LOCK = 3'd4,
        STABLE    = 3'd5,
        FAIL      = 3'd6
    } state_t;

    state_t                state, state_next;
    logic                  lock_sync;
    logic [DATA_WIDTH-1:0] shreg, shreg_d;
    logic [BCNT_W-1:0]     bit_cnt, bit_cnt_d;
    logic [TCNT_W-1:0]     tmo_cnt, tmo_cnt_d;
    logic [SCNT_W-1:0]     stb_cnt, stb_cnt_d;
    logic                  busy_d, stable_d, timeout_d;
    logic                  scanclkena_d, scandata_d, configupdate_d;

    // Raw lock is asynchronous to clock; two flops before anything looks at it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_sync <= 1'b0;
            locked    <= 1'b0;
        end else begin
            lock_sync <= pll_locked_in;
            locked    <= lock_sync;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, FAIL: if (trigger) state_next = SHIFT;
            SHIFT:      if (bit_cnt == BIT_LAST) state_next = UPDATE;
            UPDATE:     state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (scandone)                 state_next = WAIT_LOCK;
                else if (tmo_cnt >= TMO_LAST) state_next = FAIL;
            end
            WAIT_LOCK: begin
                if (locked)                   state_next = STABLE;
                else if (tmo_cnt >= TMO_LAST) state_next = FAIL;
            end
            STABLE:     if (locked && stb_cnt == STB_LAST) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Next values for every registered output and counter; all counters saturate.
    always_comb begin
        shreg_d        = shreg;
        bit_cnt_d      = bit_cnt;
        tmo_cnt_d      = tmo_cnt;
        stb_cnt_d      = stb_cnt;
        timeout_d      = timeout;
        stable_d       = stable_reconfig;
        scandata_d     = 1'b0;
        scanclkena_d   = (state_next == SHIFT);
        configupdate_d = (state_next == UPDATE);
        busy_d         = (state_next != IDLE) && (state_next != FAIL);
        unique case (state)
            IDLE, FAIL: begin
                if (trigger) begin
                    shreg_d    = PLL_DATA;
                    bit_cnt_d  = '0;
                    tmo_cnt_d  = '0;
                    timeout_d  = 1'b0;
                    stable_d   = 1'b0;
                    scandata_d = PLL_DATA[DATA_WIDTH-1];
                end else if (state == IDLE && !locked) begin
                    stable_d = 1'b0;
                end
            end
            SHIFT: begin
                if (state_next == SHIFT) begin
                    shreg_d    = shreg << 1;
                    bit_cnt_d  = bit_cnt + BCNT_W'(bit_cnt != '1);
                    scandata_d = shreg_d[DATA_WIDTH-1];
                end
            end
            UPDATE:    tmo_cnt_d = '0;
            WAIT_DONE: begin
                if (scandone) tmo_cnt_d = '0;
                else          tmo_cnt_d = tmo_cnt + TCNT_W'(tmo_cnt != '1);
            end
            WAIT_LOCK: begin
                if (locked) stb_cnt_d = '0;
                else        tmo_cnt_d = tmo_cnt + TCNT_W'(tmo_cnt != '1);
            end
            STABLE: begin
                if (!locked)                 stb_cnt_d = '0;
                else if (state_next == IDLE) stable_d  = 1'b1;
                else                         stb_cnt_d = stb_cnt + SCNT_W'(stb_cnt != '1);
            end
            default: ;
        endcase
        if (state_next == FAIL) begin
            timeout_d = 1'b1;
            stable_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg           <= '0;
            bit_cnt         <= '0;
            tmo_cnt         <= '0;
            stb_cnt         <= '0;
            busy            <= 1'b0;
            stable_reconfig <= 1'b0;
            timeout         <= 1'b0;
            scanclkena      <= 1'b0;
            scandata        <= 1'b0;
            configupdate    <= 1'b0;
        end else begin
            shreg           <= shreg_d;
            bit_cnt         <= bit_cnt_d;
            tmo_cnt         <= tmo_cnt_d;
            stb_cnt         <= stb_cnt_d;
            busy            <= busy_d;
            stable_reconfig <= stable_d;
            timeout         <= timeout_d;
            scanclkena      <= scanclkena_d;
            scandata        <= scandata_d;
            configupdate    <= configupdate_d;
        end
    end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Bench for pll_reconfig_ctrl: table of full reconfiguration transactions with a scan-bit
// scoreboard, plus hand-written timeout/retrigger and mid-shift reset sequences.
module tb_pll_reconfig_ctrl;

    logic        clock, reset_n, trigger, scandone, pll_locked_in;
    logic [15:0] PLL_DATA;
    logic        busy, stable_reconfig, timeout, locked, scanclkena, scandata, configupdate;

    int checks   = 0;
    int failures = 0;
    logic scan_q[$];

    typedef struct {
        logic [15:0] data;
        logic        retrig;
        logic [15:0] rdata;
        logic [15:0] exp_word;
        logic        glitch;
        int          exp_edges;  // clock edges from raising pll_locked_in until stable_reconfig
    } vec_t;
    vec_t vecs[4];

    pll_reconfig_ctrl #(
        .DATA_WIDTH(16),
        .STABLE_CYCLES(8),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .trigger(trigger),
        .PLL_DATA(PLL_DATA),
        .busy(busy),
        .stable_reconfig(stable_reconfig),
        .timeout(timeout),
        .locked(locked),
        .scanclkena(scanclkena),
        .scandata(scandata),
        .configupdate(configupdate),
        .scandone(scandone),
        .pll_locked_in(pll_locked_in)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        for (int b = 15; b >= 0; b--) scan_q.push_back(w[b]);
    endtask

    // Drives a one-cycle trigger; returns at the negedge after the accepting edge.
    task automatic fire(input logic [15:0] d);
        @(negedge clock);
        PLL_DATA = d;
        trigger  = 1'b1;
        @(negedge clock);
        trigger  = 1'b0;
    endtask

    // Waits (bounded) for the configupdate pulse; returns on that negedge.
    task automatic wait_update(output logic seen, output logic busy_dropped);
        seen = 1'b0;
        busy_dropped = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (configupdate) begin
                seen = 1'b1;
                break;
            end
            if (!busy) busy_dropped = 1'b1;
            @(negedge clock);
        end
    endtask

    initial begin
        logic        seen, dropped;
        logic [6:0]  outs;
        int          n, cnt, active;

        vecs[0] = '{data: 16'hA53C, retrig: 1'b0, rdata: 16'h0000, exp_word: 16'hA53C, glitch: 1'b0, exp_edges: 11};
        vecs[1] = '{data: 16'hA53C, retrig: 1'b1, rdata: 16'hFFFF, exp_word: 16'hA53C, glitch: 1'b1, exp_edges: 17};
        vecs[2] = '{data: 16'h0001, retrig: 1'b0, rdata: 16'h0000, exp_word: 16'h0001, glitch: 1'b0, exp_edges: 11};
        vecs[3] = '{data: 16'h8000, retrig: 1'b1, rdata: 16'h7FFF, exp_word: 16'h8000, glitch: 1'b0, exp_edges: 11};

        reset_n = 1'b0;
        trigger = 1'b0;
        PLL_DATA = '0;
        scandone = 1'b0;
        pll_locked_in = 1'b0;

        // Scan-bit scoreboard runs alongside the sequences below.
        fork
            forever begin
                @(negedge clock);
                if (scanclkena) begin
                    if (scan_q.size() == 0) check("scan_extra_bit", 32'(scanclkena), 32'd0);
                    else check("scandata", 32'(scandata), 32'(scan_q.pop_front()));
                end
            end
        join_none

        repeat (3) @(negedge clock);
        outs = {busy, stable_reconfig, timeout, locked, scanclkena, scandata, configupdate};
        check("reset_outputs", 32'(outs), 32'd0);
        reset_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            push_word(vecs[v].exp_word);
            fire(vecs[v].data);
            check("busy_after_trigger", 32'(busy), 32'd1);
            check("first_bit_enable", 32'(scanclkena), 32'd1);
            if (vecs[v].retrig) begin
                repeat (3) @(negedge clock);
                PLL_DATA = vecs[v].rdata;
                trigger  = 1'b1;
                @(negedge clock);
                trigger  = 1'b0;
            end
            wait_update(seen, dropped);
            check("update_seen", 32'(seen), 32'd1);
            check("busy_held_in_shift", 32'(dropped), 32'd0);
            check("scan_bits_consumed", 32'(scan_q.size()), 32'd0);
            @(negedge clock);
            check("update_one_cycle", 32'(configupdate), 32'd0);
            repeat (4) @(negedge clock);
            scandone = 1'b1;
            repeat (3) @(negedge clock);
            pll_locked_in = 1'b1;
            n = 0;
            for (int i = 1; i <= 40; i++) begin
                @(posedge clock);
                #1;
                if (stable_reconfig) begin
                    n = i;
                    break;
                end
                if (vecs[v].glitch && i == 6) pll_locked_in = 1'b0;
                if (vecs[v].glitch && i == 7) pll_locked_in = 1'b1;
            end
            check("stable_latency", 32'(n), 32'(vecs[v].exp_edges));
            check("busy_falls_with_stable", 32'(busy), 32'd0);
            check("locked", 32'(locked), 32'd1);
            scandone = 1'b0;
            @(negedge clock);
            pll_locked_in = 1'b0;
            repeat (2) @(posedge clock);
            #1;
            check("stable_held_until_seen", 32'(stable_reconfig), 32'd1);
            check("locked_dropped", 32'(locked), 32'd0);
            @(posedge clock);
            #1;
            check("stable_cleared_idle", 32'(stable_reconfig), 32'd0);
        end

        // Timeout in WAIT_DONE with scandone never arriving.
        push_word(16'h1234);
        fire(16'h1234);
        wait_update(seen, dropped);
        check("tmo_update_seen", 32'(seen), 32'd1);
        n = 0;
        for (int i = 1; i <= 130; i++) begin
            @(negedge clock);
            if (timeout) begin
                n = i;
                break;
            end
        end
        check("timeout_latency", 32'(n), 32'd101);
        check("timeout_busy_low", 32'(busy), 32'd0);
        repeat (3) @(negedge clock);
        check("timeout_sticky", 32'(timeout), 32'd1);

        // Retrigger from FAIL, then reset while bit 7 is on the scan line.
        push_word(16'h5A5A);
        fire(16'h5A5A);
        check("timeout_cleared", 32'(timeout), 32'd0);
        check("busy_restart", 32'(busy), 32'd1);
        check("shift_restart", 32'(scanclkena), 32'd1);
        repeat (8) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        outs = {busy, stable_reconfig, timeout, locked, scanclkena, scandata, configupdate};
        check("async_reset_outputs", 32'(outs), 32'd0);
        scan_q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        active = 0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (configupdate) cnt++;
            if (busy || scanclkena) active++;
        end
        check("no_update_after_reset", 32'(cnt), 32'd0);
        check("idle_after_reset", 32'(active), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
